// File: rtl/dmem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter_if
//  Description : Requester and data-memory signal bundle for dmem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if;
    logic        p0_req;
    logic [31:0] p0_addr;
    logic [2:0]  p0_memop;
    logic        p0_we;
    logic [31:0] p0_wdata;
    logic        p0_ack;
    logic        p0_err;
    logic [31:0] p0_rdata;

    logic        p1_req;
    logic [31:0] p1_addr;
    logic [2:0]  p1_memop;
    logic        p1_we;
    logic [31:0] p1_wdata;
    logic        p1_ack;
    logic        p1_err;
    logic [31:0] p1_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic [2:0]  mem_memop;
    logic        mem_we;
    logic [31:0] mem_dataout;

    // Arbiter side: consumes requests and read data, drives acks and the memory.
    modport slave (
        input  p0_req, p0_addr, p0_memop, p0_we, p0_wdata,
        output p0_ack, p0_err, p0_rdata,
        input  p1_req, p1_addr, p1_memop, p1_we, p1_wdata,
        output p1_ack, p1_err, p1_rdata,
        output mem_addr, mem_datain, mem_memop, mem_we,
        input  mem_dataout
    );

    // Environment side: requesters plus the data memory.
    modport master (
        output p0_req, p0_addr, p0_memop, p0_we, p0_wdata,
        input  p0_ack, p0_err, p0_rdata,
        output p1_req, p1_addr, p1_memop, p1_we, p1_wdata,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_addr, mem_datain, mem_memop, mem_we,
        output mem_dataout
    );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Two-port data-memory arbiter with legality checking and a
//                fixed 4-cycle (legal) / 2-cycle (rejected) transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   bus,
    output logic                 busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        last_q, last_d;
    logic        cmd_port_q, cmd_port_d;
    logic        cmd_err_q, cmd_err_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [2:0]  cmd_memop_q, cmd_memop_d;
    logic        cmd_we_q, cmd_we_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;

    logic        w_grant;
    logic        w_win;
    logic [31:0] w_sel_addr;
    logic [2:0]  w_sel_memop;
    logic        w_sel_we;
    logic [31:0] w_sel_wdata;
    logic        w_sel_err;

    function automatic logic f_access_err(input logic [2:0] memop,
                                          input logic       we,
                                          input logic [1:0] addr_lo);
        logic e;
        e = (memop[1:0] == 2'b11)
          | (memop == 3'b110)
          | (we & memop[2])
          | ((memop[1:0] == 2'b01) & addr_lo[0])
          | ((memop[1:0] == 2'b10) & (addr_lo != 2'b00));
        return e;
    endfunction

    // On a tie the port that did not win last time is chosen unless port 0 has fixed priority.
    assign w_grant     = bus.p0_req | bus.p1_req;
    assign w_win       = (bus.p0_req & bus.p1_req) ? (FIXED_PRIO ? 1'b0 : ~last_q) : bus.p1_req;
    assign w_sel_addr  = w_win ? bus.p1_addr  : bus.p0_addr;
    assign w_sel_memop = w_win ? bus.p1_memop : bus.p0_memop;
    assign w_sel_we    = w_win ? bus.p1_we    : bus.p0_we;
    assign w_sel_wdata = w_win ? bus.p1_wdata : bus.p0_wdata;
    assign w_sel_err   = f_access_err(w_sel_memop, w_sel_we, w_sel_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (w_grant) state_d = w_sel_err ? c_RESP : c_ACCESS;
            c_ACCESS: state_d = c_WAIT;
            c_WAIT:   state_d = c_RESP;
            c_RESP:   state_d = c_IDLE;
            default:  state_d = c_IDLE;
        endcase
    end

    always_comb begin
        last_d      = last_q;
        cmd_port_d  = cmd_port_q;
        cmd_err_d   = cmd_err_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_memop_d = cmd_memop_q;
        cmd_we_d    = cmd_we_q;
        cmd_wdata_d = cmd_wdata_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        case (state_q)
            c_IDLE: begin
                if (w_grant) begin
                    last_d      = w_win;
                    cmd_port_d  = w_win;
                    cmd_err_d   = w_sel_err;
                    cmd_addr_d  = w_sel_addr;
                    cmd_memop_d = w_sel_memop;
                    cmd_we_d    = w_sel_we;
                    cmd_wdata_d = w_sel_wdata;
                    // A rejected access skips WAIT, so its zero result is loaded here.
                    if (w_sel_err) begin
                        if (w_win) p1_rdata_d = '0;
                        else       p0_rdata_d = '0;
                    end
                end
            end
            c_WAIT: begin
                if (cmd_port_q) p1_rdata_d = cmd_we_q ? 32'h0 : bus.mem_dataout;
                else            p0_rdata_d = cmd_we_q ? 32'h0 : bus.mem_dataout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 1'b1;
            cmd_port_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_memop_q <= 3'b010;
            cmd_we_q    <= 1'b0;
            cmd_wdata_q <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            last_q      <= last_d;
            cmd_port_q  <= cmd_port_d;
            cmd_err_q   <= cmd_err_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_memop_q <= cmd_memop_d;
            cmd_we_q    <= cmd_we_d;
            cmd_wdata_q <= cmd_wdata_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    // Strobes are gated by rst so an aborted transaction never writes or acks.
    always_comb begin
        bus.p0_ack = 1'b0;
        bus.p0_err = 1'b0;
        bus.p1_ack = 1'b0;
        bus.p1_err = 1'b0;
        bus.mem_we = 1'b0;
        case (state_q)
            c_ACCESS: bus.mem_we = cmd_we_q & ~rst;
            c_RESP: begin
                bus.p0_ack = ~cmd_port_q & ~rst;
                bus.p0_err = ~cmd_port_q & cmd_err_q & ~rst;
                bus.p1_ack = cmd_port_q & ~rst;
                bus.p1_err = cmd_port_q & cmd_err_q & ~rst;
            end
            default: ;
        endcase
        busy = (state_q != c_IDLE);
    end

    assign bus.mem_addr   = cmd_addr_q;
    assign bus.mem_datain = cmd_wdata_q;
    assign bus.mem_memop  = cmd_memop_q;
    assign bus.p0_rdata   = p0_rdata_q;
    assign bus.p1_rdata   = p1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_port_arbiter
//  Description : Scoreboard bench for dmem_port_arbiter with a byte memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic busy_fp;
    logic mem_load;

    always #5 clk = ~clk;

    dmem_port_arbiter_if bus();
    dmem_port_arbiter_if bus_fp();

    dmem_port_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    dmem_port_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_fp),
        .busy (busy_fp)
    );

    assign bus_fp.mem_dataout = 32'h0;

    // Byte memory with 1-cycle read latency; steering/extension done here.
    logic [7:0] mem [0:1023];

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] op);
        logic [9:0] i;
        i = a[9:0];
        case (op)
            3'b000:  return {{24{mem[i][7]}}, mem[i]};
            3'b100:  return {24'h0, mem[i]};
            3'b001:  return {{16{mem[i+10'd1][7]}}, mem[i+10'd1], mem[i]};
            3'b101:  return {16'h0, mem[i+10'd1], mem[i]};
            default: return {mem[i+10'd3], mem[i+10'd2], mem[i+10'd1], mem[i]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_load) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 8'h00;
            mem[10'h104] <= 8'h0D; mem[10'h105] <= 8'hF0; mem[10'h106] <= 8'hAD; mem[10'h107] <= 8'h0B;
            mem[10'h200] <= 8'h0D; mem[10'h201] <= 8'hF0; mem[10'h202] <= 8'hFE; mem[10'h203] <= 8'hCA;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[9:0]] <= bus.mem_datain[7:0];
            if (bus.mem_memop[1:0] != 2'b00) mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_datain[15:8];
            if (bus.mem_memop[1] == 1'b1) begin
                mem[bus.mem_addr[9:0] + 10'd2] <= bus.mem_datain[23:16];
                mem[bus.mem_addr[9:0] + 10'd3] <= bus.mem_datain[31:24];
            end
        end
        bus.mem_dataout <= mem_rd(bus.mem_addr, bus.mem_memop);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_exp(input logic port, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    // Monitor: every ack is matched against the oldest expected response.
    always @(negedge clk) begin
        if (bus.p0_ack || bus.p1_ack) begin
            exp_t e;
            if (bus.p0_ack && bus.p1_ack) chk("sb_dual_ack", {30'h0, bus.p1_ack, bus.p0_ack}, 32'h1);
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ack", {30'h0, bus.p1_ack, bus.p0_ack}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_port",  {31'h0, bus.p1_ack}, {31'h0, e.port});
                chk("sb_err",   {31'h0, e.port ? bus.p1_err : bus.p0_err}, {31'h0, e.err});
                chk("sb_rdata", e.port ? bus.p1_rdata : bus.p0_rdata, e.rdata);
            end
        end
    end

    task automatic drive(input logic port, input logic req, input logic [31:0] addr,
                         input logic [2:0] op, input logic we, input logic [31:0] wd);
        if (!port) begin
            bus.p0_req = req; bus.p0_addr = addr; bus.p0_memop = op; bus.p0_we = we; bus.p0_wdata = wd;
        end else begin
            bus.p1_req = req; bus.p1_addr = addr; bus.p1_memop = op; bus.p1_we = we; bus.p1_wdata = wd;
        end
    endtask

    // Issue one transaction, check latency and the cycle(s) in which mem_we was high.
    task automatic run_txn(input string tag, input logic port, input logic [31:0] addr,
                           input logic [2:0] op, input logic we, input logic [31:0] wd,
                           input logic exp_err, input logic [31:0] exp_rd);
        int          n;
        logic        seen;
        logic [31:0] we_bits;
        push_exp(port, exp_err, exp_rd);
        @(posedge clk); #1;
        drive(port, 1'b1, addr, op, we, wd);
        n = 0; seen = 1'b0; we_bits = '0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (bus.mem_we && n < 32) we_bits[n] = 1'b1;
            seen = port ? bus.p1_ack : bus.p0_ack;
            n++;
        end
        drive(port, 1'b0, addr, op, 1'b0, wd);
        chk({tag, "_latency"}, n, exp_err ? 32'd2 : 32'd4);
        chk({tag, "_mem_we"}, we_bits, (we && !exp_err) ? 32'h2 : 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n1;
        int n2;
        logic seen;
        logic [1:0] exp_rr;
        logic [1:0] exp_fp;

        rst = 1'b1; mem_load = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 3'b010, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 3'b010, 1'b0, 32'h0);
        bus_fp.p0_req = 1'b0; bus_fp.p0_addr = 32'h100; bus_fp.p0_memop = 3'b010; bus_fp.p0_we = 1'b0; bus_fp.p0_wdata = 32'h0;
        bus_fp.p1_req = 1'b0; bus_fp.p1_addr = 32'h104; bus_fp.p1_memop = 3'b010; bus_fp.p1_we = 1'b0; bus_fp.p1_wdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_p0_ack",     {31'h0, bus.p0_ack}, 32'h0);
        chk("rst_p1_ack",     {31'h0, bus.p1_ack}, 32'h0);
        chk("rst_p0_err",     {31'h0, bus.p0_err}, 32'h0);
        chk("rst_p1_err",     {31'h0, bus.p1_err}, 32'h0);
        chk("rst_p0_rdata",   bus.p0_rdata, 32'h0);
        chk("rst_p1_rdata",   bus.p1_rdata, 32'h0);
        chk("rst_mem_we",     {31'h0, bus.mem_we}, 32'h0);
        chk("rst_mem_addr",   bus.mem_addr, 32'h0);
        chk("rst_mem_datain", bus.mem_datain, 32'h0);
        chk("rst_mem_memop",  {29'h0, bus.mem_memop}, 32'h2);
        chk("rst_busy",       {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; mem_load = 1'b0;

        run_txn("sw100",     1'b0, 32'h100, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        run_txn("lw100",     1'b0, 32'h100, 3'b010, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF);
        run_txn("lb103",     1'b0, 32'h103, 3'b000, 1'b0, 32'h0,        1'b0, 32'hFFFFFFDE);
        run_txn("lbu103",    1'b0, 32'h103, 3'b100, 1'b0, 32'h0,        1'b0, 32'h000000DE);
        run_txn("lhu102",    1'b0, 32'h102, 3'b101, 1'b0, 32'h0,        1'b0, 32'h0000DEAD);
        run_txn("sw102_mis", 1'b0, 32'h102, 3'b010, 1'b1, 32'h11111111, 1'b1, 32'h0);
        run_txn("lw100_chk", 1'b0, 32'h100, 3'b010, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF);
        run_txn("lh102",     1'b1, 32'h102, 3'b001, 1'b0, 32'h0,        1'b0, 32'hFFFFDEAD);
        run_txn("op011",     1'b1, 32'h100, 3'b011, 1'b0, 32'h0,        1'b1, 32'h0);
        run_txn("sb_op100",  1'b1, 32'h100, 3'b100, 1'b1, 32'h000000AA, 1'b1, 32'h0);
        run_txn("lh101_mis", 1'b1, 32'h101, 3'b001, 1'b0, 32'h0,        1'b1, 32'h0);
        run_txn("op110",     1'b1, 32'h100, 3'b110, 1'b0, 32'h0,        1'b1, 32'h0);
        chk("p0_rdata_hold", bus.p0_rdata, 32'hDEADBEEF);

        // Reset pulsed during the ACCESS cycle of a store.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 32'h200, 3'b010, 1'b1, 32'h12345678);
        @(posedge clk); #1;
        chk("rstw_busy_access", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h200, 3'b010, 1'b0, 32'h0);
        @(negedge clk);
        chk("rstw_mem_we", {31'h0, bus.mem_we}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstw_no_ack", {30'h0, bus.p1_ack, bus.p0_ack}, 32'h0);
            if (i == 0) chk("rstw_idle", {31'h0, busy}, 32'h0);
        end
        run_txn("lw200", 1'b1, 32'h200, 3'b010, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D);

        // Contention: both ports hold lw for 16 cycles on both arbiter variants.
        push_exp(1'b0, 1'b0, 32'hDEADBEEF);
        push_exp(1'b1, 1'b0, 32'h0BADF00D);
        push_exp(1'b0, 1'b0, 32'hDEADBEEF);
        push_exp(1'b1, 1'b0, 32'h0BADF00D);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h100, 3'b010, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h104, 3'b010, 1'b0, 32'h0);
        bus_fp.p0_req = 1'b1;
        bus_fp.p1_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_rr = (i == 3 || i == 11) ? 2'b01 : ((i == 7 || i == 15) ? 2'b10 : 2'b00);
            exp_fp = (i % 4 == 3) ? 2'b01 : 2'b00;
            chk("rr_ack", {30'h0, bus.p1_ack, bus.p0_ack}, {30'h0, exp_rr});
            chk("fp_ack", {30'h0, bus_fp.p1_ack, bus_fp.p0_ack}, {30'h0, exp_fp});
        end
        drive(1'b0, 1'b0, 32'h100, 3'b010, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h104, 3'b010, 1'b0, 32'h0);
        bus_fp.p0_req = 1'b0;
        bus_fp.p1_req = 1'b0;
        repeat (4) @(negedge clk);

        // Back-to-back from port 0 with the command changed in the ack cycle.
        push_exp(1'b0, 1'b0, 32'hDEADBEEF);
        push_exp(1'b0, 1'b0, 32'h0BADF00D);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h100, 3'b010, 1'b0, 32'h0);
        n1 = 0; seen = 1'b0;
        while (!seen && n1 < 40) begin
            @(negedge clk);
            seen = bus.p0_ack;
            n1++;
        end
        drive(1'b0, 1'b1, 32'h104, 3'b010, 1'b0, 32'h0);
        n2 = 0; seen = 1'b0;
        while (!seen && n2 < 40) begin
            @(negedge clk);
            seen = bus.p0_ack;
            n2++;
        end
        drive(1'b0, 1'b0, 32'h104, 3'b010, 1'b0, 32'h0);
        chk("b2b_first_latency", n1, 32'd4);
        chk("b2b_gap", n2, 32'd4);

        repeat (6) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
